mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving the log2 word depth (256 x 32-bit words).
REQ-002 SHALL have parameter WAIT, default 2, range 0..15, giving the number of wait cycles before access completion.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous and active-low.
REQ-005 SHALL have port MemRead, input, 1, the read request strobe from the controller.
REQ-006 SHALL have port MemWrite, input, 1, the write request strobe from the controller.
REQ-007 SHALL have port Address, input, 32, a byte address; word index = Address[ADDR_W+1:2].
REQ-008 SHALL have port WriteData, input, 32, the store data.
REQ-009 SHALL have port ReadData, output, 32, the registered load data.
REQ-010 SHALL have port MemReady, output, 1, a one-cycle completion pulse.
REQ-011 SHALL have port MemBusy, output, 1, high while a request is held (WAIT or RESP state).
REQ-012 SHALL have port AddrError, output, 1, a one-cycle pulse with MemReady when a request is rejected.

Function
REQ-013 SHALL implement the FSM states IDLE, WAIT, RESP; MemBusy = (state != IDLE).
REQ-014 In IDLE, SHALL accept a request when exactly one of MemRead/MemWrite is high; SHALL capture Address, WriteData and the request type; and SHALL load the wait counter with WAIT.
REQ-015 On acceptance, SHALL go to WAIT if WAIT>0, else to RESP.
REQ-016 In WAIT, SHALL decrement the counter each cycle and go to RESP on the cycle the counter reaches 1.
REQ-017 In RESP, for a write, SHALL store the captured data into mem[index]; for a read, SHALL load ReadData <= mem[index]. In both cases SHALL assert MemReady for exactly this cycle and return to IDLE next.
REQ-018 Latency SHALL be WAIT+1 cycles from the acceptance edge to the MemReady cycle; back-to-back requests SHALL be accepted in the cycle after RESP (in IDLE).
REQ-019 Request inputs SHALL be ignored while MemBusy=1; input changes after acceptance SHALL have no effect.
REQ-020 MemRead and MemWrite both high in IDLE SHALL be rejected: no memory access, go to RESP with AddrError=1, ReadData unchanged.
REQ-021 A misaligned address (captured Address[1:0] != 0) SHALL be rejected identically: no access, AddrError=1 with MemReady, after the normal WAIT+1 latency.
REQ-022 Address bits above ADDR_W+1 SHALL be ignored (index wrap-around); e.g. 0x400 and 0x000 address the same word when ADDR_W=8.
REQ-023 ReadData SHALL hold its value between reads; writes and rejected requests SHALL NOT change it.
REQ-024 A write then a read of the same index SHALL return the written data (no stale read).

Reset
REQ-025 While rst=0 at a clock edge: state <= IDLE, counter <= 0, ReadData <= 0, MemReady <= 0, AddrError <= 0, MemBusy = 0.
REQ-026 Memory array contents SHALL NOT be cleared by reset.
REQ-027 Reset asserted during WAIT SHALL abort the request: no write is performed and no MemReady is issued.
REQ-028 Requests presented while rst=0 SHALL be ignored.

Verification
REQ-029 WAIT=2: MemWrite, Address=0x10, WriteData=0xDEADBEEF at edge T -> MemBusy T+1..T+3, MemReady only in the cycle after edge T+2; then MemRead at 0x10 -> ReadData=0xDEADBEEF coincident with MemReady.
REQ-030 MemRead and MemWrite both high, Address=0x20 -> AddrError=1 and MemReady=1 together; mem[8] unchanged; ReadData unchanged.
REQ-031 MemRead at Address=0x13 -> AddrError pulse after WAIT+1 cycles; ReadData keeps its previous value.
REQ-032 Write 0x12345678 to 0x404, then read 0x004 (ADDR_W=8) -> ReadData=0x12345678.
REQ-033 Start write 0xAAAA5555 to 0x30; drive rst=0 during WAIT for one edge -> no MemReady; a later read of 0x30 returns the prior contents.
REQ-034 Change Address/WriteData/strobes every cycle while MemBusy=1 -> only the originally captured request completes, and exactly one MemReady is issued.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: wait-state word memory that answers single read/write requests with a ready pulse
module mem_responder #(
  parameter int ADDR_W = 8,
  parameter int WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemBusy,
  output logic        AddrError
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic cap_rd, cap_wr;
  logic [ADDR_W+1:0] cap_addr, e_addr;
  logic [31:0] cap_data, e_data;
  logic e_rd, e_wr, err, go, idle;
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic unused_addr;
  assign unused_addr = &{1'b0, Address[31:ADDR_W+2]};
  assign idle = state == S_IDLE;
  assign MemBusy = !idle;
  always_comb begin
    e_rd = idle ? MemRead : cap_rd;
    e_wr = idle ? MemWrite : cap_wr;
    e_addr = idle ? Address[ADDR_W+1:0] : cap_addr;
    e_data = idle ? WriteData : cap_data;
    err = (e_rd && e_wr) || (e_addr[1:0] != 2'b00);
    state_n = state;
    case (state)
      S_IDLE: state_n = (MemRead && MemWrite) ? S_RESP :
                        (MemRead || MemWrite) ? ((WAIT > 0) ? S_WAIT : S_RESP) : S_IDLE;
      S_WAIT: state_n = (cnt == 4'd1) ? S_RESP : S_WAIT;
      default: state_n = S_IDLE;
    endcase
    go = state_n == S_RESP;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt <= '0;
      ReadData <= '0;
      MemReady <= 1'b0;
      AddrError <= 1'b0;
    end else begin
      state <= state_n;
      if (idle) begin
        cap_rd <= MemRead;
        cap_wr <= MemWrite;
        cap_addr <= Address[ADDR_W+1:0];
        cap_data <= WriteData;
        cnt <= 4'(WAIT);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      MemReady <= go;
      AddrError <= go && err;
      if (go && !err && e_rd) ReadData <= mem[e_addr[ADDR_W+1:2]];
    end
  end
  always_ff @(posedge clk)
    if (rst && go && !err && e_wr) mem[e_addr[ADDR_W+1:2]] <= e_data;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized + directed check of mem_responder against a word-array reference model
module tb_mem_responder;
  localparam int WAIT = 2;
  logic clk = 0, rst = 0, MemRead = 0, MemWrite = 0;
  logic [31:0] Address = 0, WriteData = 0, ReadData;
  logic MemReady, MemBusy, AddrError;
  int vectors = 0, miscompares = 0;
  logic [31:0] model [256];
  logic [31:0] exp_rd = 0;

  mem_responder #(.ADDR_W(8), .WAIT(WAIT)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .MemReady(MemReady), .MemBusy(MemBusy), .AddrError(AddrError)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d, input bit scramble);
    bit err;
    int n, lat;
    err = (rd && wr) || (a[1:0] != 2'b00);
    lat = (rd && wr) ? 1 : WAIT + 1;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Address = a; WriteData = d;
    @(negedge clk);
    n = 1;
    while (MemReady !== 1'b1 && n < 40) begin
      check("busy_wait", 32'(MemBusy), 1);
      if (scramble) begin
        MemRead = 1'($urandom); MemWrite = 1'($urandom);
        Address = $urandom; WriteData = $urandom;
      end else begin
        MemRead = 0; MemWrite = 0;
      end
      @(negedge clk);
      n++;
    end
    check("latency", n, lat);
    check("busy_resp", 32'(MemBusy), 1);
    check("addr_error", 32'(AddrError), 32'(err));
    if (!err) begin
      if (wr) model[a[9:2]] = d;
      if (rd) exp_rd = model[a[9:2]];
    end
    check("read_data", ReadData, exp_rd);
    MemRead = 0; MemWrite = 0;
    @(negedge clk);
    check("ready_pulse", 32'(MemReady), 0);
    check("err_pulse", 32'(AddrError), 0);
    check("back_idle", 32'(MemBusy), 0);
  endtask

  initial begin
    MemRead = 1; Address = 32'h40;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(MemBusy), 0);
    check("rst_ready", 32'(MemReady), 0);
    check("rst_err", 32'(AddrError), 0);
    check("rst_rdata", ReadData, 0);
    MemRead = 0;
    rst = 1;
    for (int i = 0; i < 256; i++) req(0, 1, (32'($urandom_range(0, 255)) << 10) | (32'(i) << 2), $urandom, 0);
    req(0, 1, 32'h10, 32'hDEADBEEF, 0);
    req(1, 0, 32'h10, 0, 0);
    check("deadbeef", ReadData, 32'hDEADBEEF);
    req(1, 1, 32'h20, $urandom, 0);
    req(1, 0, 32'h20, 0, 0);
    req(1, 0, 32'h13, 0, 0);
    req(0, 1, 32'h404, 32'h12345678, 0);
    req(1, 0, 32'h004, 0, 0);
    check("wrap_read", ReadData, 32'h12345678);
    @(negedge clk);
    MemWrite = 1; Address = 32'h30; WriteData = 32'hAAAA5555;
    @(negedge clk);
    MemWrite = 0;
    check("abort_busy", 32'(MemBusy), 1);
    rst = 0;
    @(negedge clk);
    rst = 1;
    exp_rd = 0;
    check("abort_idle", 32'(MemBusy), 0);
    check("abort_rdata", ReadData, 0);
    for (int i = 0; i < 4; i++) begin
      check("abort_noready", 32'(MemReady), 0);
      @(negedge clk);
    end
    req(1, 0, 32'h30, 0, 0);
    for (int i = 0; i < 20; i++) req(1'(i % 2), 1'((i + 1) % 2), {$urandom_range(0, 63), 2'b00}, $urandom, 1);
    for (int i = 0; i < 300; i++) begin
      int t;
      logic [31:0] a;
      t = $urandom_range(0, 9);
      a = $urandom;
      if ($urandom_range(0, 6) != 0) a[1:0] = 2'b00;
      req(t < 4 || t == 9, t >= 4, a, $urandom, 1'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
